impulse_capture_sequencer: RTL and testbench

//  Top-level controller for impulse-response calibration. On one request it steps through
//  NUM_CHANNELS output channels and, per channel, fires the impulse recorder, waits for its

---
 rtl/impulse_capture_sequencer.sv | 171 +++++++++++++++++
 tb/tb_impulse_capture_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/impulse_capture_sequencer.sv
// Impulse-response calibration sequencer.
//
// A single cal_start walks through NUM_CHANNELS output channels. For each channel the
// recorder is fired (record_trigger), its completion level (impulse_recorded) is awaited
// with a sample-count timeout, a silence gap is enforced, and the recorder is re-armed
// (redo_impulse) before the next channel. A timed-out capture is retried up to MAX_RETRIES
// times; after that the channel is flagged in fail_mask and the run carries on.
//
// Ports
//   audio_clk         system clock, rising edge
//   rst_in            synchronous active-high reset
//   audio_trigger     one-cycle pulse per audio sample period
//   cal_start         one-cycle run request (ignored while busy)
//   cal_abort         abandon the run in progress (ignored when idle)
//   impulse_recorded  recorder level: capture for the current channel is complete
//   record_trigger    one-cycle pulse: fire impulse and start capture
//   redo_impulse      one-cycle pulse: re-arm the recorder
//   channel_sel       channel currently being calibrated
//   busy              high from run start until completion or abort
//   cal_done          one-cycle pulse on normal run completion
//   fail_mask         bit i set when channel i exhausted its retries
module impulse_capture_sequencer #(
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned TIMEOUT_SAMPLES = 48000,
  parameter int unsigned GAP_SAMPLES     = 4800,
  parameter int unsigned MAX_RETRIES     = 2,
  localparam int unsigned ChW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    audio_clk,
  input  logic                    rst_in,
  input  logic                    audio_trigger,
  input  logic                    cal_start,
  input  logic                    cal_abort,
  input  logic                    impulse_recorded,
  output logic                    record_trigger,
  output logic                    redo_impulse,
  output logic [ChW-1:0]          channel_sel,
  output logic                    busy,
  output logic                    cal_done,
  output logic [NUM_CHANNELS-1:0] fail_mask
);

  localparam int unsigned CntMax = (TIMEOUT_SAMPLES > GAP_SAMPLES) ? TIMEOUT_SAMPLES
                                                                   : GAP_SAMPLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  // The counter is compared against limit-1 on a trigger, so the trigger that would bring
  // it to the limit is the one that fires; it never has to hold the limit itself.
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_SAMPLES - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(GAP_SAMPLES - 1);
  localparam logic [2:0]      RetryLimit  = 3'(MAX_RETRIES);
  localparam logic [ChW-1:0]  LastCh      = ChW'(NUM_CHANNELS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StCapture,
    StSettle,
    StRearm,
    StDone
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] sample_cnt_q;
  logic [2:0]      retries_q;
  // Set when leaving SETTLE: the REARM that follows moves on to the next channel rather
  // than retrying the current one.
  logic            advance_q;

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state_q        <= StIdle;
      sample_cnt_q   <= '0;
      retries_q      <= '0;
      advance_q      <= 1'b0;
      record_trigger <= 1'b0;
      redo_impulse   <= 1'b0;
      channel_sel    <= '0;
      busy           <= 1'b0;
      cal_done       <= 1'b0;
      fail_mask      <= '0;
    end else begin
      record_trigger <= 1'b0;
      redo_impulse   <= 1'b0;
      cal_done       <= 1'b0;

      if (cal_abort && (state_q != StIdle)) begin
        // Abort overrides every transition; the recorder is re-armed so it is left clean.
        state_q      <= StIdle;
        redo_impulse <= 1'b1;
        busy         <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cal_start) begin
              state_q     <= StArm;
              channel_sel <= '0;
              retries_q   <= '0;
              fail_mask   <= '0;
              busy        <= 1'b1;
            end
          end

          StArm: begin
            record_trigger <= 1'b1;
            sample_cnt_q   <= '0;
            state_q        <= StCapture;
          end

          StCapture: begin
            // A completion seen on the timeout trigger still counts as a good capture.
            if (impulse_recorded) begin
              sample_cnt_q <= '0;
              state_q      <= StSettle;
            end else if (audio_trigger) begin
              if (sample_cnt_q == TimeoutLast) begin
                sample_cnt_q <= '0;
                if (retries_q < RetryLimit) begin
                  retries_q <= retries_q + 3'd1;
                  advance_q <= 1'b0;
                  state_q   <= StRearm;
                end else begin
                  fail_mask[channel_sel] <= 1'b1;
                  state_q                <= StSettle;
                end
              end else begin
                sample_cnt_q <= sample_cnt_q + CntW'(1);
              end
            end
          end

          StSettle: begin
            if (audio_trigger) begin
              if (sample_cnt_q == GapLast) begin
                advance_q <= 1'b1;
                state_q   <= StRearm;
              end else begin
                sample_cnt_q <= sample_cnt_q + CntW'(1);
              end
            end
          end

          StRearm: begin
            redo_impulse <= 1'b1;
            if (!advance_q) begin
              state_q <= StArm;
            end else if (channel_sel == LastCh) begin
              state_q <= StDone;
            end else begin
              channel_sel <= channel_sel + ChW'(1);
              retries_q   <= '0;
              state_q     <= StArm;
            end
          end

          StDone: begin
            cal_done <= 1'b1;
            busy     <= 1'b0;
            state_q  <= StIdle;
          end

          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_impulse_capture_sequencer.sv
// Bench for impulse_capture_sequencer: a behavioural recorder answers each record_trigger
// after a planned number of audio triggers (or never); a per-run expectation is derived
// from that plan and compared with the observed pulse stream.
module tb_impulse_capture_sequencer;

  localparam int NumCh      = 2;
  localparam int Timeout    = 8;
  localparam int Gap        = 4;
  localparam int MaxRetries = 1;
  localparam int Attempts   = MaxRetries + 1;
  localparam int RunLimit   = 3000;

  logic       audio_clk;
  logic       rst_in;
  logic       audio_trigger;
  logic       cal_start;
  logic       cal_abort;
  logic       impulse_recorded;
  logic       record_trigger;
  logic       redo_impulse;
  logic [0:0] channel_sel;
  logic       busy;
  logic       cal_done;
  logic [1:0] fail_mask;

  impulse_capture_sequencer #(
    .NUM_CHANNELS   (NumCh),
    .TIMEOUT_SAMPLES(Timeout),
    .GAP_SAMPLES    (Gap),
    .MAX_RETRIES    (MaxRetries)
  ) dut (
    .audio_clk       (audio_clk),
    .rst_in          (rst_in),
    .audio_trigger   (audio_trigger),
    .cal_start       (cal_start),
    .cal_abort       (cal_abort),
    .impulse_recorded(impulse_recorded),
    .record_trigger  (record_trigger),
    .redo_impulse    (redo_impulse),
    .channel_sel     (channel_sel),
    .busy            (busy),
    .cal_done        (cal_done),
    .fail_mask       (fail_mask)
  );

  initial audio_clk = 1'b0;
  always #5 audio_clk = ~audio_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Recorder model. plan[c][a] = trigger index (counted from the record_trigger cycle) on
  // which attempt a of channel c completes; 0 means it never completes.
  int   plan [NumCh][Attempts];
  int   rt_per_ch [NumCh];
  logic armed_q;
  logic level_q;
  int   cnt_q;
  int   d_q;
  int   d_now;
  int   base_cnt;
  int   att_idx;
  logic hit;

  always_comb begin
    att_idx  = rt_per_ch[channel_sel];
    if (att_idx >= Attempts) att_idx = Attempts - 1;
    d_now    = d_q;
    base_cnt = cnt_q;
    if (record_trigger) begin
      d_now    = plan[channel_sel][att_idx];
      base_cnt = 0;
    end
    hit = audio_trigger && (record_trigger || armed_q) && (base_cnt + 1 == d_now);
  end

  assign impulse_recorded = level_q | hit;

  always @(posedge audio_clk) begin
    if (rst_in || redo_impulse) begin
      armed_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= 0;
    end else if (record_trigger) begin
      armed_q <= 1'b1;
      d_q     <= d_now;
      cnt_q   <= audio_trigger ? 1 : 0;
      if (hit) level_q <= 1'b1;
    end else if (armed_q && audio_trigger) begin
      cnt_q <= cnt_q + 1;
      if (hit) level_q <= 1'b1;
    end
    if (!rst_in && !busy && cal_start) begin
      for (int i = 0; i < NumCh; i++) rt_per_ch[i] <= 0;
    end else if (!rst_in && record_trigger) begin
      rt_per_ch[channel_sel] <= rt_per_ch[channel_sel] + 1;
    end
  end

  // Observation state, all owned by the main process.
  int   cyc   = 0;
  int   phase = 0;
  int   got_ch[$];
  int   got_win[$];
  int   exp_ch[$];
  int   exp_win[$];
  int   exp_fail;
  int   n_rt;
  int   n_redo;
  int   n_done;
  int   n_overlap;
  logic win_open;
  int   win_cnt;

  task automatic clear_mon();
    got_ch.delete();
    got_win.delete();
    n_rt      = 0;
    n_redo    = 0;
    n_done    = 0;
    n_overlap = 0;
    win_open  = 1'b0;
    win_cnt   = 0;
  endtask

  // Window = audio triggers from a record_trigger cycle up to (excluding) its redo cycle.
  task automatic monitor();
    if (record_trigger && redo_impulse) n_overlap++;
    if (record_trigger) begin
      n_rt++;
      got_ch.push_back(int'(channel_sel));
      win_open = 1'b1;
      win_cnt  = audio_trigger ? 1 : 0;
    end else if (win_open && !redo_impulse && audio_trigger) begin
      win_cnt++;
    end
    if (redo_impulse) begin
      n_redo++;
      if (win_open) got_win.push_back(win_cnt);
      win_open = 1'b0;
    end
    if (cal_done) n_done++;
  endtask

  task automatic tick();
    @(negedge audio_clk);
    monitor();
    @(posedge audio_clk);
    #1;
    cyc++;
    audio_trigger = ((cyc % 4) == phase);
  endtask

  // Expected per-run outcome from the plan: one window per attempt.
  task automatic build_expect();
    exp_ch.delete();
    exp_win.delete();
    exp_fail = 0;
    for (int c = 0; c < NumCh; c++) begin
      for (int a = 0; a < Attempts; a++) begin
        exp_ch.push_back(c);
        if (plan[c][a] >= 1 && plan[c][a] <= Timeout) begin
          exp_win.push_back(plan[c][a] + Gap);
          break;
        end else if (a < MaxRetries) begin
          exp_win.push_back(Timeout);
        end else begin
          exp_win.push_back(Timeout + Gap);
          exp_fail |= (1 << c);
        end
      end
    end
  endtask

  task automatic set_plan(input int d00, input int d01, input int d10, input int d11);
    plan[0][0] = d00;
    plan[0][1] = d01;
    plan[1][0] = d10;
    plan[1][1] = d11;
  endtask

  task automatic run(input string name, input bit poke);
    int n;
    int m;
    clear_mon();
    build_expect();
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    check_eq({name, ".busy_start"}, busy, 1);
    check_eq({name, ".mask_clear"}, fail_mask, 0);
    tick();
    check_eq({name, ".rt_latency"}, record_trigger, 1);
    n = 0;
    while (busy && n < RunLimit) begin
      cal_start = poke && (n == 20);
      tick();
      n++;
    end
    cal_start = 1'b0;
    check_eq({name, ".terminates"}, int'(n < RunLimit), 1);
    tick();
    tick();
    check_eq({name, ".n_record"}, n_rt, exp_ch.size());
    check_eq({name, ".n_redo"}, n_redo, exp_ch.size());
    m = (got_ch.size() < exp_ch.size()) ? got_ch.size() : exp_ch.size();
    for (int i = 0; i < m; i++) check_eq($sformatf("%s.ch[%0d]", name, i), got_ch[i], exp_ch[i]);
    m = (got_win.size() < exp_win.size()) ? got_win.size() : exp_win.size();
    for (int i = 0; i < m; i++)
      check_eq($sformatf("%s.win[%0d]", name, i), got_win[i], exp_win[i]);
    check_eq({name, ".fail_mask"}, fail_mask, exp_fail);
    check_eq({name, ".cal_done"}, n_done, 1);
    check_eq({name, ".overlap"}, n_overlap, 0);
  endtask

  initial begin
    int n;
    rst_in        = 1'b1;
    audio_trigger = 1'b0;
    cal_start     = 1'b0;
    cal_abort     = 1'b0;
    set_plan(3, 3, 3, 3);
    for (int i = 0; i < NumCh; i++) rt_per_ch[i] = 0;
    clear_mon();
    repeat (3) tick();
    check_eq("reset.outputs", {record_trigger, redo_impulse, channel_sel, busy, cal_done,
                               fail_mask}, 0);
    rst_in = 1'b0;
    tick();
    cal_abort = 1'b1;  // abort while idle must do nothing
    tick();
    cal_abort = 1'b0;
    check_eq("idle_abort.redo", redo_impulse, 0);

    set_plan(3, 3, 3, 3);
    run("normal", 1'b0);
    set_plan(0, 0, 3, 3);
    run("ch0_dead", 1'b0);
    set_plan(Timeout, 3, 3, 3);
    run("edge_timeout", 1'b0);
    set_plan(2, 2, 5, 5);
    run("start_ignored", 1'b1);

    // Abort during SETTLE of channel 0.
    set_plan(3, 3, 3, 3);
    clear_mon();
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    n = 0;
    while (!impulse_recorded && n < 200) begin
      tick();
      n++;
    end
    check_eq("abort.reach_settle", int'(n < 200), 1);
    tick();
    tick();
    cal_abort = 1'b1;
    tick();
    cal_abort = 1'b0;
    check_eq("abort.redo", redo_impulse, 1);
    check_eq("abort.busy", busy, 0);
    check_eq("abort.record", record_trigger, 0);
    tick();
    check_eq("abort.redo_single", redo_impulse, 0);
    repeat (30) tick();
    check_eq("abort.no_done", n_done, 0);
    check_eq("abort.no_restart", n_rt, 1);
    run("after_abort", 1'b0);

    // Reset while in CAPTURE.
    clear_mon();
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check_eq("midreset.outputs", {record_trigger, redo_impulse, channel_sel, busy, cal_done,
                                  fail_mask}, 0);
    repeat (20) tick();
    check_eq("midreset.no_redo", n_redo, 0);
    check_eq("midreset.idle", busy, 0);
    run("after_reset", 1'b0);

    // Randomised plans and trigger phase.
    for (int r = 0; r < 14; r++) begin
      phase = int'($urandom_range(0, 3));
      for (int c = 0; c < NumCh; c++)
        for (int a = 0; a < Attempts; a++)
          plan[c][a] = int'($urandom_range(0, 11));
      run($sformatf("rand%0d", r), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
